// File: rtl/banked_dp_ram_pkg.sv
// Shared types and width helpers for the banked dual-port RAM.
package banked_ram_pkg;

  typedef enum logic {
    PORT_A = 1'b0,
    PORT_B = 1'b1
  } port_e;

  localparam int unsigned MAX_R_LATENCY = 8;

  function automatic int unsigned bank_idx_w(input int unsigned num_banks);
    return $clog2(num_banks);
  endfunction

  function automatic int unsigned row_idx_w(input int unsigned depth, input int unsigned num_banks);
    return $clog2(depth) - $clog2(num_banks);
  endfunction

endpackage

// File: rtl/banked_dp_ram_if.sv
// Request/response bundle for both RAM ports.
interface banked_dp_ram_if #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned ADDR_WIDTH = 4
);
  logic                  ena, wea, rdya, valida;
  logic [ADDR_WIDTH-1:0] addra;
  logic [DATA_WIDTH-1:0] dina, douta;
  logic                  enb, web, rdyb, validb;
  logic [ADDR_WIDTH-1:0] addrb;
  logic [DATA_WIDTH-1:0] dinb, doutb;

  modport master (
    output ena, wea, addra, dina, enb, web, addrb, dinb,
    input  rdya, douta, valida, rdyb, doutb, validb
  );

  modport slave (
    input  ena, wea, addra, dina, enb, web, addrb, dinb,
    output rdya, douta, valida, rdyb, doutb, validb
  );
endinterface

// File: rtl/dp_rd_pipe.sv
// Read-data delay line: valid/data shift register plus a holding output register.
module dp_rd_pipe #(
  parameter int unsigned WIDTH   = 8,
  parameter int unsigned LATENCY = 1
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_valid,
  input  logic [WIDTH-1:0] i_data,
  output logic             o_valid,
  output logic [WIDTH-1:0] o_data
);

  logic [LATENCY-1:0] vld_q, vld_d;
  logic [WIDTH-1:0]   dat_q [LATENCY];
  logic [WIDTH-1:0]   dat_d [LATENCY];
  logic               out_vld_q, out_vld_d;
  logic [WIDTH-1:0]   out_dat_q, out_dat_d;

  always_comb begin
    vld_d[0] = i_valid;
    dat_d[0] = i_data;
    for (int unsigned i = 1; i < LATENCY; i++) begin
      vld_d[i] = vld_q[i-1];
      dat_d[i] = dat_q[i-1];
    end
    out_vld_d = vld_q[LATENCY-1];
    out_dat_d = vld_q[LATENCY-1] ? dat_q[LATENCY-1] : out_dat_q;
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      vld_q     <= '0;
      dat_q     <= '{default: '0};
      out_vld_q <= 1'b0;
      out_dat_q <= '0;
    end else begin
      vld_q     <= vld_d;
      dat_q     <= dat_d;
      out_vld_q <= out_vld_d;
      out_dat_q <= out_dat_d;
    end
  end

  assign o_valid = out_vld_q;
  assign o_data  = out_dat_q;

endmodule

// File: rtl/banked_dp_ram.sv
// Dual-port RAM built from single-port banks; same-bank collisions are
// resolved by a round-robin pointer that flips only on conflict cycles.
module banked_dp_ram
  import banked_ram_pkg::*;
#(
  parameter int unsigned DATA_WIDTH    = 8,
  parameter int unsigned ADDRESS_DEPTH = 16,
  parameter int unsigned NUM_BANKS     = 4,
  parameter int unsigned A_R_LATENCY   = 1,
  parameter int unsigned B_R_LATENCY   = 1
) (
  input  logic                             i_clk,
  input  logic                             i_rst,
  input  logic                             i_ena,
  input  logic                             i_enb,
  input  logic                             i_wea,
  input  logic                             i_web,
  input  logic [$clog2(ADDRESS_DEPTH)-1:0] i_addra,
  input  logic [$clog2(ADDRESS_DEPTH)-1:0] i_addrb,
  input  logic [DATA_WIDTH-1:0]            i_dina,
  input  logic [DATA_WIDTH-1:0]            i_dinb,
  output logic                             o_rdya,
  output logic                             o_rdyb,
  output logic [DATA_WIDTH-1:0]            o_douta,
  output logic [DATA_WIDTH-1:0]            o_doutb,
  output logic                             o_valida,
  output logic                             o_validb
);

  localparam int unsigned BW   = bank_idx_w(NUM_BANKS);
  localparam int unsigned RW   = row_idx_w(ADDRESS_DEPTH, NUM_BANKS);
  localparam int unsigned BWS  = (BW > 0) ? BW : 1;
  localparam int unsigned RWS  = (RW > 0) ? RW : 1;
  localparam int unsigned ROWS = ADDRESS_DEPTH / NUM_BANKS;

  if (ADDRESS_DEPTH < 2 || (ADDRESS_DEPTH & (ADDRESS_DEPTH - 1)) != 0) begin : g_bad_depth
    $error("ADDRESS_DEPTH must be a power of two >= 2");
  end
  if (NUM_BANKS < 1 || NUM_BANKS > ADDRESS_DEPTH || (NUM_BANKS & (NUM_BANKS - 1)) != 0) begin : g_bad_banks
    $error("NUM_BANKS must be a power of two in 1..ADDRESS_DEPTH");
  end
  if (A_R_LATENCY < 1 || A_R_LATENCY > MAX_R_LATENCY ||
      B_R_LATENCY < 1 || B_R_LATENCY > MAX_R_LATENCY) begin : g_bad_latency
    $error("read latencies must be in 1..MAX_R_LATENCY");
  end

  logic [BWS-1:0]        bank_a, bank_b;
  logic [RWS-1:0]        row_a, row_b;
  logic                  conflict, acc_a, acc_b;
  logic                  wr_a, wr_b, rd_a, rd_b;
  logic [DATA_WIDTH-1:0] rd_data_a, rd_data_b;
  logic [DATA_WIDTH-1:0] bank_rd_a [NUM_BANKS];
  logic [DATA_WIDTH-1:0] bank_rd_b [NUM_BANKS];
  port_e                 rr_q, rr_d;

  // Modulo/shift keep a single-bank build free of zero-width slices.
  always_comb begin
    bank_a    = BWS'(32'(i_addra) % NUM_BANKS);
    bank_b    = BWS'(32'(i_addrb) % NUM_BANKS);
    row_a     = RWS'(32'(i_addra) >> BW);
    row_b     = RWS'(32'(i_addrb) >> BW);
    conflict  = i_ena && i_enb && (bank_a == bank_b);
    o_rdya    = !conflict || (rr_q == PORT_A);
    o_rdyb    = !conflict || (rr_q == PORT_B);
    acc_a     = i_ena && o_rdya;
    acc_b     = i_enb && o_rdyb;
    wr_a      = acc_a && i_wea;
    wr_b      = acc_b && i_web;
    rd_a      = acc_a && !i_wea;
    rd_b      = acc_b && !i_web;
    rd_data_a = bank_rd_a[bank_a];
    rd_data_b = bank_rd_b[bank_b];
    rr_d      = rr_q;
    if (conflict) rr_d = (rr_q == PORT_A) ? PORT_B : PORT_A;
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) rr_q <= PORT_A;
    else       rr_q <= rr_d;
  end

  for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
    logic [DATA_WIDTH-1:0] mem [ROWS];
    logic                  we_a, we_b;

    assign we_a = wr_a && (bank_a == BWS'(b));
    assign we_b = wr_b && (bank_b == BWS'(b));

    // Arbitration guarantees at most one accepted port per bank per cycle.
    always_ff @(posedge i_clk) begin
      if (we_a)      mem[row_a] <= i_dina;
      else if (we_b) mem[row_b] <= i_dinb;
    end

    assign bank_rd_a[b] = mem[row_a];
    assign bank_rd_b[b] = mem[row_b];
  end

  dp_rd_pipe #(.WIDTH(DATA_WIDTH), .LATENCY(A_R_LATENCY)) u_pipe_a (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_valid (rd_a),
    .i_data  (rd_data_a),
    .o_valid (o_valida),
    .o_data  (o_douta)
  );

  dp_rd_pipe #(.WIDTH(DATA_WIDTH), .LATENCY(B_R_LATENCY)) u_pipe_b (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_valid (rd_b),
    .i_data  (rd_data_b),
    .o_valid (o_validb),
    .o_data  (o_doutb)
  );

endmodule
